// File: rtl/cut_bist_pkg.sv
// Shared definitions for the CUT BIST harness: FSM state encoding, default
// Galois feedback masks and the right-shift Galois step used by both the
// pattern LFSR and the response MISR.
package cut_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCheck,
    StDone
  } bist_state_e;

  // Widest register galois_step can serve; callers zero-extend into it.
  localparam int unsigned StepMaxW = 32;

  // x^13+x^4+x^3+x+1, maximal length (period 8191).
  localparam logic [12:0] LfsrTapsDefault = 13'h100D;
  // x^21+x^19+1.
  localparam logic [20:0] MisrTapsDefault = 21'h140000;

  // nxt = (s >> 1) ^ (s[0] ? taps : 0) ^ d
  function automatic logic [StepMaxW-1:0] galois_step(input logic [StepMaxW-1:0] s,
                                                      input logic [StepMaxW-1:0] taps,
                                                      input logic [StepMaxW-1:0] d);
    return (s >> 1) ^ (s[0] ? taps : '0) ^ d;
  endfunction

endpackage

// File: rtl/cut_bist_galois_reg.sv
// Galois right-shift register with parallel load, step enable and data
// injection. Used as an LFSR (d_i tied to zero) or as a MISR (d_i = response).
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset, clears the register
//   load_i      load load_val_i (takes priority over en_i)
//   load_val_i  parallel load value
//   en_i        advance one Galois step, folding in d_i
//   d_i         data injected into the step
//   q_o         register contents
module cut_bist_galois_reg
  import cut_bist_pkg::*;
#(
  // Must not exceed StepMaxW.
  parameter int unsigned      Width = 13,
  parameter logic [Width-1:0] Taps  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = Width'(galois_step(StepMaxW'(q_q), StepMaxW'(Taps), StepMaxW'(d_i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cut_bist_stim_misr.sv
// BIST harness for a 13-in / 21-out combinational CUT. An LFSR drives
// pseudo-random patterns, a MISR compacts the responses, and the final
// signature is compared against a golden value.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset (aborts any run)
//   start_i         begin a run; honoured only in IDLE or DONE
//   num_patterns_i  number of patterns, sampled with start_i
//   golden_sig_i    expected signature, sampled in CHECK
//   pat_out_o       registered pattern to the CUT (bit 0 = N1)
//   pat_valid_o     pat_out_o carries a live pattern
//   rsp_in_i        CUT response, combinational from pat_out_o (bit 0 = N286)
//   busy_o          run in progress (RUN or CHECK)
//   done_o          result valid, held until the next start
//   pass_o          signature matched golden_sig_i; valid while done_o
//   signature_o     current MISR contents
module cut_bist_stim_misr
  import cut_bist_pkg::*;
#(
  parameter int unsigned     PatW     = 13,
  parameter int unsigned     RspW     = 21,
  parameter int unsigned     CntW     = 16,
  // Must be non-zero or the LFSR locks up.
  parameter logic [PatW-1:0] LfsrSeed = PatW'(1),
  parameter logic [PatW-1:0] LfsrTaps = LfsrTapsDefault,
  parameter logic [RspW-1:0] MisrTaps = MisrTapsDefault
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [CntW-1:0] num_patterns_i,
  input  logic [RspW-1:0] golden_sig_i,
  output logic [PatW-1:0] pat_out_o,
  output logic            pat_valid_o,
  input  logic [RspW-1:0] rsp_in_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [RspW-1:0] signature_o
);

  bist_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            pat_valid_q, busy_q, done_q, pass_q;
  logic [RspW-1:0] misr_q;

  logic start_ok, run_go, lfsr_en, misr_en;

  assign start_ok = start_i & ((state_q == StIdle) | (state_q == StDone));
  assign run_go   = start_ok & (num_patterns_i != '0);
  // The last pattern is held on pat_out_o rather than advanced.
  assign lfsr_en  = (state_q == StRun) & (cnt_q != CntW'(1));
  assign misr_en  = (state_q == StRun);

  cut_bist_galois_reg #(
    .Width(PatW),
    .Taps (LfsrTaps)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (run_go),
    .load_val_i(LfsrSeed),
    .en_i      (lfsr_en),
    .d_i       ('0),
    .q_o       (pat_out_o)
  );

  // Cleared on every accepted start, including zero-length runs.
  cut_bist_galois_reg #(
    .Width(RspW),
    .Taps (MisrTaps)
  ) u_misr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start_ok),
    .load_val_i('0),
    .en_i      (misr_en),
    .d_i       (rsp_in_i),
    .q_o       (misr_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            if (num_patterns_i != '0) begin
              cnt_q       <= num_patterns_i;
              pat_valid_q <= 1'b1;
              state_q     <= StRun;
            end else begin
              state_q <= StCheck;
            end
          end
        end
        StRun: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            pat_valid_q <= 1'b0;
            state_q     <= StCheck;
          end
        end
        StCheck: begin
          pass_q  <= (misr_q == golden_sig_i);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pat_valid_o = pat_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign signature_o = misr_q;

endmodule
